fmac_pktctrl_rd: RTL and testbench

- Downstream consumer of the 4Kx32 packet-control FIFO and its companion 64-bit packet-data FIFO in the LMAC core.
- Pops one 32-bit control word per packet and reads exactly ceil(len/8) data beats.
- Presents the packet on a valid/ready stream with sop/eop/byte-enables, or silently flushes it when the drop flag is set.
- Keeps per-packet statistics.

---
 rtl/fmac_pktctrl_rd.sv | 148 ++++++++++++++
 tb/tb_fmac_pktctrl_rd.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fmac_pktctrl_rd.sv
// fmac_pktctrl_rd: pops one control word per packet, streams its data beats on valid/ready or flushes them.
// Statistics counters are built only when FMAC_PKTCTRL_STAT_EN is defined.
module fmac_pktctrl_rd #(
  parameter int DWIDTH = 64,
  parameter int CWIDTH = 32,
  parameter int LEN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  ctrl_rdempty,
  output logic                  ctrl_rdreq,
  input  logic [CWIDTH-1:0]     ctrl_q,
  input  logic                  data_rdempty,
  output logic                  data_rdreq,
  input  logic [DWIDTH-1:0]     data_q,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DWIDTH-1:0]     tx_data,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic [DWIDTH/8-1:0]   tx_be,
  output logic                  tx_err,
  output logic                  busy,
  output logic [31:0]           pkt_cnt,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           bad_cnt
);
  localparam int BW = LEN_W - 2;
  localparam int NB = DWIDTH / 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_CWAIT = 2'd1, S_DATA = 2'd2, S_FLUSH = 2'd3;
  logic [1:0] state_q, state_d, occ_q, occ_d, occ_m, buf_sop_q, buf_sop_d, buf_eop_q, buf_eop_d;
  logic [BW-1:0] req_left_q, req_left_d, nb_q, nb_d, nb;
  logic [2:0] len_lo_q, len_lo_d;
  logic err_q, err_d, infl_q, infl_d, infl_sop_q, infl_sop_d, infl_eop_q, infl_eop_d;
  logic [DWIDTH-1:0] buf_data_q [2];
  logic [DWIDTH-1:0] buf_data_d [2];
  logic [DWIDTH-1:0] head_data;
  logic [LEN_W-1:0] ctrl_len;
  logic [NB-1:0] last_be;
  logic head_sop, head_eop, pop, pop_buf, store, eop_hs, len_zero, flush_done;
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_q[CWIDTH-1:LEN_W+2];
  // A read issued last cycle returns on data_q and is presented directly when the buffer is empty.
  always_comb begin
    ctrl_len   = ctrl_q[LEN_W-1:0];
    nb         = BW'(({1'b0, ctrl_len} + (LEN_W+1)'(7)) >> 3);
    head_data  = occ_q != 2'd0 ? buf_data_q[0] : data_q;
    head_sop   = occ_q != 2'd0 ? buf_sop_q[0] : infl_sop_q;
    head_eop   = occ_q != 2'd0 ? buf_eop_q[0] : infl_eop_q;
    last_be    = len_lo_q == 3'd0 ? '1 : ~({NB{1'b1}} << len_lo_q);
    tx_valid   = state_q == S_DATA && (occ_q != 2'd0 || infl_q);
    pop        = tx_valid && tx_ready;
    eop_hs     = pop && head_eop;
    tx_data    = tx_valid ? head_data : '0;
    tx_sop     = tx_valid && head_sop;
    tx_eop     = tx_valid && head_eop;
    tx_be      = tx_valid ? (head_eop ? last_be : '1) : '0;
    tx_err     = tx_valid && err_q;
    busy       = state_q != S_IDLE || occ_q != 2'd0;
    len_zero   = state_q == S_CWAIT && ctrl_len == '0;
    flush_done = state_q == S_FLUSH && infl_q && infl_eop_q;
    ctrl_rdreq = reset_ && !ctrl_rdempty && (state_q == S_IDLE || eop_hs);
    data_rdreq = reset_ && !data_rdempty && req_left_q != '0 &&
                 (state_q == S_FLUSH || (state_q == S_DATA && occ_q + 2'(infl_q) < 2'd2));
    state_d    = ctrl_rdreq ? S_CWAIT
               : state_q == S_CWAIT ? (len_zero ? S_IDLE : ctrl_q[LEN_W+1] ? S_FLUSH : S_DATA)
               : (eop_hs || flush_done) ? S_IDLE : state_q;
    req_left_d = state_q == S_CWAIT ? nb : req_left_q - BW'(data_rdreq);
    nb_d       = state_q == S_CWAIT ? nb : nb_q;
    len_lo_d   = state_q == S_CWAIT ? ctrl_len[2:0] : len_lo_q;
    err_d      = state_q == S_CWAIT ? ctrl_q[LEN_W] : err_q;
    infl_d     = data_rdreq;
    infl_sop_d = req_left_q == nb_q;
    infl_eop_d = req_left_q == BW'(1);
    pop_buf    = pop && occ_q != 2'd0;
    occ_m      = occ_q - 2'(pop_buf);
    store      = state_q == S_DATA && infl_q && !(pop && occ_q == 2'd0);
    occ_d      = occ_m + 2'(store);
    buf_data_d = buf_data_q;
    buf_sop_d  = buf_sop_q;
    buf_eop_d  = buf_eop_q;
    if (pop_buf) begin
      buf_data_d[0] = buf_data_q[1];
      buf_sop_d[0]  = buf_sop_q[1];
      buf_eop_d[0]  = buf_eop_q[1];
    end
    if (store) begin
      buf_data_d[occ_m[0]] = data_q;
      buf_sop_d[occ_m[0]]  = infl_sop_q;
      buf_eop_d[occ_m[0]]  = infl_eop_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q    <= S_IDLE;
      req_left_q <= '0;
      nb_q       <= '0;
      len_lo_q   <= '0;
      err_q      <= 1'b0;
      infl_q     <= 1'b0;
      infl_sop_q <= 1'b0;
      infl_eop_q <= 1'b0;
      occ_q      <= '0;
      buf_sop_q  <= '0;
      buf_eop_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_left_q <= req_left_d;
      nb_q       <= nb_d;
      len_lo_q   <= len_lo_d;
      err_q      <= err_d;
      infl_q     <= infl_d;
      infl_sop_q <= infl_sop_d;
      infl_eop_q <= infl_eop_d;
      occ_q      <= occ_d;
      buf_sop_q  <= buf_sop_d;
      buf_eop_q  <= buf_eop_d;
    end
  end
  always_ff @(posedge clk) buf_data_q <= buf_data_d;
`ifdef FMAC_PKTCTRL_STAT_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d, bad_cnt_q, bad_cnt_d;
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q + 32'(eop_hs && !(&pkt_cnt_q));
    drop_cnt_d = drop_cnt_q + 16'(flush_done && !(&drop_cnt_q));
    bad_cnt_d  = bad_cnt_q + 16'(len_zero && !(&bad_cnt_q));
  end
  always_ff @(posedge clk) begin
    if (!reset_) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign bad_cnt  = bad_cnt_q;
`else
  assign pkt_cnt  = '0;
  assign drop_cnt = '0;
  assign bad_cnt  = '0;
`endif
endmodule

// File: tb/tb_fmac_pktctrl_rd.sv
// tb_fmac_pktctrl_rd: directed bench with FIFO models and a beat scoreboard for fmac_pktctrl_rd.
module tb_fmac_pktctrl_rd;
  logic clk = 1'b0, reset_ = 1'b0, ctrl_rdempty = 1'b1, data_rdempty = 1'b1, tx_ready = 1'b1;
  logic ctrl_rdreq, data_rdreq, tx_valid, tx_sop, tx_eop, tx_err, busy;
  logic [31:0] ctrl_q = '0, pkt_cnt;
  logic [63:0] data_q = '0, tx_data;
  logic [7:0] tx_be;
  logic [15:0] drop_cnt, bad_cnt;
  typedef struct packed {logic [63:0] d; logic sop; logic eop; logic [7:0] be; logic err;} beat_t;
  logic [31:0] cq[$];
  logic [63:0] dq[$];
  beat_t eq[$];
  int checks = 0, errors = 0, cyc = 0, nbeats = 0, cr_cyc = -1, tv_cyc = -1;
  int sop_cyc = 0, eop_cyc = 0, gap = 0, pid = 0, drq_cnt = 0, base = 0;
  int exp_pkt = 0, exp_drop = 0, exp_bad = 0;
  bit toggle = 0, data_hold = 0, c_req, d_req, stall_q = 0;
  logic [75:0] stall_vec = '0;
  always #5 clk = ~clk;
  fmac_pktctrl_rd dut (
    .clk(clk), .reset_(reset_), .ctrl_rdempty(ctrl_rdempty), .ctrl_rdreq(ctrl_rdreq), .ctrl_q(ctrl_q),
    .data_rdempty(data_rdempty), .data_rdreq(data_rdreq), .data_q(data_q), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_be(tx_be),
    .tx_err(tx_err), .busy(busy), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .bad_cnt(bad_cnt)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic upd();
    ctrl_rdempty = cq.size() == 0;
    data_rdempty = dq.size() == 0 || data_hold;
  endtask
  task automatic tick();
    logic [75:0] v;
    beat_t e;
    upd();
    @(negedge clk);
    cyc++;
    v = {tx_valid, tx_data, tx_sop, tx_eop, tx_be, tx_err};
    if (ctrl_rdreq) begin
      check("c_rdreq_when_empty", ctrl_rdempty, 0);
      if (cr_cyc < 0) cr_cyc = cyc;
    end
    if (data_rdreq) begin
      check("d_rdreq_when_empty", data_rdempty, 0);
      drq_cnt++;
    end
    if (tx_valid && tv_cyc < 0) tv_cyc = cyc;
    if (stall_q) check("stable_while_stalled", v, stall_vec);
    stall_q = tx_valid && !tx_ready;
    stall_vec = v;
    if (tx_valid && tx_ready) begin
      nbeats++;
      if (tx_sop) begin gap = cyc - eop_cyc; sop_cyc = cyc; end
      if (tx_eop) eop_cyc = cyc;
      if (eq.size() == 0) check("extra_beat", tx_valid, 0);
      else begin e = eq.pop_front(); check("beat", v[74:0], e); end
    end
    c_req = ctrl_rdreq;
    d_req = data_rdreq;
    @(posedge clk);
    #1;
    if (c_req && cq.size() != 0) ctrl_q = cq.pop_front();
    if (d_req && dq.size() != 0) data_q = dq.pop_front();
    tx_ready = toggle ? !tx_ready : 1'b1;
    upd();
  endtask
  task automatic add_pkt(input logic [31:0] cw);
    int l, b;
    beat_t e;
    l = int'(cw[13:0]);
    b = (l + 7) / 8;
    pid++;
    cq.push_back(cw);
    for (int i = 0; i < b; i++) begin
      e.d = {16'hD000 + 16'(pid), 16'(i), 32'h1234_5678 ^ 32'(i * 7)};
      dq.push_back(e.d);
      e.sop = i == 0;
      e.eop = i == b - 1;
      e.be = (e.eop && l % 8 != 0) ? 8'((1 << (l % 8)) - 1) : 8'hFF;
      e.err = cw[14];
      if (!cw[15]) eq.push_back(e);
    end
    if (l == 0) exp_bad++;
    else if (cw[15]) exp_drop++;
    else exp_pkt++;
  endtask
  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    do begin tick(); n++; end while (n < budget && (eq.size() != 0 || cq.size() != 0 || busy));
    check(tag, eq.size() != 0 || cq.size() != 0 || busy, 0);
  endtask
  task automatic check_cnts(input string tag);
    int ep = exp_pkt, ed = exp_drop, eb = exp_bad;
`ifndef FMAC_PKTCTRL_STAT_EN
    ep = 0; ed = 0; eb = 0;
`endif
    check({tag, "_pkt_cnt"}, pkt_cnt, ep);
    check({tag, "_drop_cnt"}, drop_cnt, ed);
    check({tag, "_bad_cnt"}, bad_cnt, eb);
  endtask
  initial begin
    tick();
    tick();
    check("rst_out", {ctrl_rdreq, data_rdreq, tx_valid, tx_sop, tx_eop, tx_be, tx_err, tx_data, busy}, 0);
    check_cnts("rst");
    reset_ = 1'b1;
    base = nbeats; cr_cyc = -1; tv_cyc = -1;
    add_pkt(32'h0000_0040);
    wait_done("t1_done", 60);
    check("t1_latency", tv_cyc - cr_cyc, 3);
    check("t1_burst", eop_cyc - sop_cyc, 7);
    check("t1_beats", nbeats - base, 8);
    check_cnts("t1");
    base = nbeats; toggle = 1;
    add_pkt(32'h0000_003D);
    wait_done("t2_done", 80);
    toggle = 0; tx_ready = 1'b1;
    check("t2_beats", nbeats - base, 8);
    base = nbeats;
    add_pkt(32'h0000_803C);
    add_pkt(32'h0000_0008);
    wait_done("t3_done", 80);
    check("t3_dq_consumed", dq.size(), 0);
    check("t3_beats", nbeats - base, 1);
    check_cnts("t3");
    base = nbeats;
    add_pkt(32'h0000_0000);
    add_pkt(32'h0000_4010);
    wait_done("t4_done", 60);
    check("t4_beats", nbeats - base, 2);
    check_cnts("t4");
    base = nbeats;
    add_pkt(32'd80);
    for (int n = 0; n < 40 && nbeats - base < 3; n++) tick();
    data_hold = 1; drq_cnt = 0;
    repeat (20) tick();
    check("t5_hold_rdreq", drq_cnt, 0);
    check("t5_partial", nbeats - base < 10, 1);
    data_hold = 0;
    wait_done("t5_done", 60);
    check("t5_beats", nbeats - base, 10);
    base = nbeats;
    add_pkt(32'd1500);
    add_pkt(32'd1500);
    wait_done("t6_done", 600);
    check("t6_beats", nbeats - base, 376);
    check("t6_burst", eop_cyc - sop_cyc, 187);
    check("t6_gap_le3", gap <= 3, 1);
    check_cnts("t6");
    add_pkt(32'd64);
    repeat (5) tick();
    check("t7_midpkt_busy", busy, 1);
    reset_ = 1'b0;
    tick();
    cq.delete(); dq.delete(); eq.delete();
    exp_pkt = 0; exp_drop = 0; exp_bad = 0;
    upd();
    #1;
    check("t7_rst_out", {ctrl_rdreq, data_rdreq, tx_valid, tx_sop, tx_eop, tx_be, tx_err, tx_data, busy}, 0);
    check_cnts("t7");
    tick();
    reset_ = 1'b1;
    base = nbeats;
    add_pkt(32'd16);
    wait_done("t8_done", 40);
    check("t8_beats", nbeats - base, 2);
    check_cnts("t8");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
